jpeg_coeff_expander: RTL and testbench

- Next-generation JPEG entropy back-end: takes Huffman-decoded (run, size, value) symbols and sign-extends the value.
- Applies per-component DC prediction, expands zero runs, ZRL and EOB into a full 64-coefficient stream per block.
- Sits between the Huffman symbol decoder and the de-zigzag/dequantiser, with valid/ready handshakes on both sides.

---
 rtl/jpeg_coeff_expander.sv | 164 ++++++++++++++++
 tb/tb_jpeg_coeff_expander.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_coeff_expander.sv
// jpeg_coeff_expander: turns Huffman-decoded (run, size, value) symbols into a
// 64-beat coefficient stream per block. It sign-extends each value, applies
// per-component DC prediction, and expands zero runs, ZRL and EOB.
module jpeg_coeff_expander #(
  parameter int COEFF_WIDTH    = 12,
  parameter int MAX_SIZE       = 11,
  parameter int NUM_COMPONENTS = 3,
  parameter bit DELTA_DECODE   = 1'b1,
  localparam int COMP_W = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [MAX_SIZE-1:0]           value_in,
  input  logic [3:0]                    run_in,
  input  logic [4:0]                    size_in,
  input  logic                          dc_in,
  input  logic [COMP_W-1:0]             comp_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          restart_in,
  output logic signed [COEFF_WIDTH-1:0] coeff_out,
  output logic [5:0]                    index_out,
  output logic [COMP_W-1:0]             comp_out,
  output logic                          last_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          error_out
);

  localparam int EXT_W = ((COEFF_WIDTH > MAX_SIZE) ? COEFF_WIDTH : MAX_SIZE) + 1;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_RUN    = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  state_t                        state;
  logic [5:0]                    exp_idx;
  logic [5:0]                    run_idx;
  logic [5:0]                    end_idx;
  logic signed [COEFF_WIDTH-1:0] pend_val;
  logic [COMP_W-1:0]             pend_comp;
  logic signed [COEFF_WIDTH-1:0] pred [NUM_COMPONENTS];

  logic                          out_free;
  logic                          accept;
  logic                          size_bad;
  logic                          comp_ok;
  logic                          is_eob;
  logic                          overrun;
  logic [EXT_W-1:0]              val_w;
  logic [EXT_W-1:0]              pow_w;
  logic signed [COEFF_WIDTH-1:0] ext;
  logic signed [COEFF_WIDTH-1:0] pred_sel;
  logic signed [COEFF_WIDTH-1:0] dc_sum;
  logic signed [COEFF_WIDTH-1:0] dc_coeff;
  logic signed [COEFF_WIDTH-1:0] ac_val;
  logic [6:0]                    run_end;
  logic [5:0]                    ac_end;

  assign out_free  = !valid_out || ready_in;
  assign ready_out = !rst_in && (state == ST_ACCEPT) && out_free;
  assign accept    = valid_in && ready_out;

  // Sign-extend the raw magnitude bits according to their JPEG category
  always_comb begin
    size_bad = (size_in > 5'(MAX_SIZE));
    val_w    = EXT_W'(value_in);
    pow_w    = EXT_W'(1) << size_in;
    ext      = '0;
    if ((size_in != 5'd0) && !size_bad) begin
      if (val_w >= (pow_w >> 1)) ext = COEFF_WIDTH'(val_w);
      else                       ext = COEFF_WIDTH'(val_w - pow_w + EXT_W'(1));
    end
  end

  // Predictor lookup and where the incoming AC symbol ends inside the block
  always_comb begin
    comp_ok  = (int'(comp_in) < NUM_COMPONENTS);
    pred_sel = '0;
    if (comp_ok && !restart_in) pred_sel = pred[comp_in];
    dc_sum   = pred_sel + ext;
    dc_coeff = DELTA_DECODE ? dc_sum : ext;
    is_eob   = (run_in == 4'd0) && (size_in == 5'd0);
    run_end  = {1'b0, exp_idx} + {3'b000, run_in};
    overrun  = !is_eob && (run_end > 7'd63);
    ac_end   = (is_eob || overrun) ? 6'd63 : run_end[5:0];
    ac_val   = (is_eob || overrun) ? '0 : ext;
  end

  // Control FSM, predictors and the registered output beat
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_ACCEPT;
      exp_idx   <= 6'd0;
      run_idx   <= 6'd0;
      end_idx   <= 6'd0;
      pend_val  <= '0;
      pend_comp <= '0;
      coeff_out <= '0;
      index_out <= 6'd0;
      comp_out  <= '0;
      last_out  <= 1'b0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      for (int i = 0; i < NUM_COMPONENTS; i++) pred[i] <= '0;
    end else begin
      if (restart_in) begin
        for (int i = 0; i < NUM_COMPONENTS; i++) pred[i] <= '0;
        error_out <= 1'b0;
      end
      if (out_free) valid_out <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (accept) begin
            valid_out <= 1'b1;
            comp_out  <= comp_in;
            if (size_bad) error_out <= 1'b1;
            if (dc_in) begin
              if (exp_idx != 6'd0) error_out <= 1'b1;
              coeff_out <= dc_coeff;
              index_out <= 6'd0;
              last_out  <= 1'b0;
              exp_idx   <= 6'd1;
              if (DELTA_DECODE && comp_ok) pred[comp_in] <= dc_sum;
            end else begin
              if ((exp_idx == 6'd0) || overrun) error_out <= 1'b1;
              index_out <= exp_idx;
              last_out  <= (exp_idx == 6'd63);
              coeff_out <= (exp_idx == ac_end) ? ac_val : '0;
              if (exp_idx == ac_end) begin
                exp_idx <= exp_idx + 6'd1;
              end else begin
                state     <= is_eob ? ST_FILL : ST_RUN;
                run_idx   <= exp_idx + 6'd1;
                end_idx   <= ac_end;
                pend_val  <= ac_val;
                pend_comp <= comp_in;
              end
            end
          end
        end
        ST_RUN, ST_FILL: begin
          if (out_free) begin
            valid_out <= 1'b1;
            comp_out  <= pend_comp;
            index_out <= run_idx;
            last_out  <= (run_idx == 6'd63);
            coeff_out <= (run_idx == end_idx) ? pend_val : '0;
            if (run_idx == end_idx) begin
              state   <= ST_ACCEPT;
              exp_idx <= run_idx + 6'd1;
            end else begin
              run_idx <= run_idx + 6'd1;
            end
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_coeff_expander.sv
// tb_jpeg_coeff_expander: directed and randomized symbols driven into the
// expander; every output beat is compared against a block-level model.
module tb_jpeg_coeff_expander;

  localparam int CW    = 12;
  localparam int MS    = 11;
  localparam int NC    = 3;
  localparam int COMPW = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic [MS-1:0]        value_in = '0;
  logic [3:0]           run_in = '0;
  logic [4:0]           size_in = '0;
  logic                 dc_in = 1'b0;
  logic [COMPW-1:0]     comp_in = '0;
  logic                 valid_in = 1'b0;
  logic                 ready_out;
  logic                 restart_in = 1'b0;
  logic signed [CW-1:0] coeff_out;
  logic [5:0]           index_out;
  logic [COMPW-1:0]     comp_out;
  logic                 last_out;
  logic                 valid_out;
  logic                 ready_in = 1'b1;
  logic                 error_out;

  jpeg_coeff_expander #(
    .COEFF_WIDTH(CW),
    .MAX_SIZE(MS),
    .NUM_COMPONENTS(NC),
    .DELTA_DECODE(1'b1)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .value_in(value_in),
    .run_in(run_in),
    .size_in(size_in),
    .dc_in(dc_in),
    .comp_in(comp_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .restart_in(restart_in),
    .coeff_out(coeff_out),
    .index_out(index_out),
    .comp_out(comp_out),
    .last_out(last_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .error_out(error_out)
  );

  // Free-running clock
  always #5 clk_in = ~clk_in;

  typedef struct {
    int coeff;
    int idx;
    int comp;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    pred_m [NC];
  int    idx_m;
  bit    err_m;
  int    checks = 0;
  int    failures = 0;
  int    beats_seen = 0;
  int    lasts_seen = 0;
  int    bp_mode = 0;
  int    pat_i = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int signExt(input int size, input int value);
    if (size == 0 || size > MS) return 0;
    if (value >= (1 << (size - 1))) return value;
    return value - (1 << size) + 1;
  endfunction

  function automatic int wrapCoeff(input int x);
    int w;
    w = x & ((1 << CW) - 1);
    if (w >= (1 << (CW - 1))) w -= (1 << CW);
    return w;
  endfunction

  function automatic int randValue(input int size);
    if (size == 0) return 0;
    if (size > MS) return int'($urandom_range(0, (1 << MS) - 1));
    return int'($urandom_range(0, (1 << size) - 1));
  endfunction

  function automatic logic pickReady();
    logic r;
    r = 1'b1;
    if (bp_mode == 1) r = logic'($urandom_range(0, 1));
    if (bp_mode == 2) begin
      r = (pat_i % 4 == 0) || (pat_i % 4 == 3);
      pat_i++;
    end
    return r;
  endfunction

  task automatic pushBeat(input int c, input int i, input int comp);
    beat_t b;
    b.coeff = c;
    b.idx   = i;
    b.comp  = comp;
    b.last  = (i == 63);
    exp_q.push_back(b);
  endtask

  task automatic modelSymbol(input bit dc, input int comp, input int run, input int size, input int value, input bit rs);
    int sx;
    sx = signExt(size, value);
    if (rs) begin
      for (int i = 0; i < NC; i++) pred_m[i] = 0;
      err_m = 1'b0;
    end
    if (size > MS) err_m = 1'b1;
    if (dc) begin
      if (idx_m != 0) err_m = 1'b1;
      pred_m[comp] = wrapCoeff(pred_m[comp] + sx);
      pushBeat(pred_m[comp], 0, comp);
      idx_m = 1;
    end else begin
      if (idx_m == 0) err_m = 1'b1;
      if (run == 0 && size == 0) begin
        for (int i = idx_m; i < 64; i++) pushBeat(0, i, comp);
        idx_m = 0;
      end else if (idx_m + run > 63) begin
        for (int i = idx_m; i < 64; i++) pushBeat(0, i, comp);
        err_m = 1'b1;
        idx_m = 0;
      end else begin
        for (int i = idx_m; i < idx_m + run; i++) pushBeat(0, i, comp);
        pushBeat(sx, idx_m + run, comp);
        idx_m = (idx_m + run + 1) % 64;
      end
    end
  endtask

  task automatic printSummary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic checkOutput(input int partial);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      if (partial > 0 && n >= partial) break;
      if (n >= 400) begin
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      ready_in = pickReady();
      #1;
      chk("valid", valid_out, 1);
      if (valid_out === 1'b1) begin
        chk("coeff", $signed(coeff_out), exp_q[0].coeff);
        chk("index", index_out, exp_q[0].idx);
        chk("comp", comp_out, exp_q[0].comp);
        chk("last", last_out, exp_q[0].last);
        if (exp_q.size() > 1) chk("ready_busy", ready_out, 0);
        if (ready_in) begin
          beats_seen++;
          if (last_out) lasts_seen++;
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk_in);
      n++;
    end
  endtask

  task automatic applyStimulus(input bit dc, input int comp, input int run, input int size, input int value, input bit rs, input int partial = 0);
    int waitn;
    waitn = 0;
    modelSymbol(dc, comp, run, size, value, rs);
    @(negedge clk_in);
    dc_in      = dc;
    comp_in    = COMPW'(comp);
    run_in     = 4'(run);
    size_in    = 5'(size);
    value_in   = MS'(value);
    restart_in = rs;
    valid_in   = 1'b1;
    ready_in   = 1'b1;
    #1;
    while (!ready_out) begin
      if (waitn > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout ready_out=0 required=1");
        printSummary();
        $fatal(1, "[TB] symbol never accepted");
      end
      @(negedge clk_in);
      #1;
      waitn++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in   = 1'b0;
    restart_in = 1'b0;
    chk("latency_valid", valid_out, 1);
    checkOutput(partial);
  endtask

  // Directed steps followed by randomized blocks
  initial begin
    int comp, sz, k, r;
    idx_m = 0;
    err_m = 1'b0;
    for (int i = 0; i < NC; i++) pred_m[i] = 0;

    repeat (2) @(negedge clk_in);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready_out, 0);
    chk("rst_coeff", $signed(coeff_out), 0);
    chk("rst_index", index_out, 0);
    chk("rst_comp", comp_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_error", error_out, 0);
    rst_in = 1'b0;

    $display("[TB] sign extension");
    applyStimulus(1, 0, 0, 3, 2, 1);
    applyStimulus(1, 0, 0, 3, 5, 1);
    applyStimulus(1, 0, 0, 11, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] DC prediction");
    applyStimulus(1, 0, 0, 4, 10, 1);
    applyStimulus(1, 1, 0, 3, 4, 0);
    applyStimulus(1, 0, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] run expansion");
    beats_seen = 0;
    lasts_seen = 0;
    applyStimulus(1, 0, 0, 3, 5, 1);
    applyStimulus(0, 0, 2, 2, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    chk("block_beats", beats_seen, 64);
    chk("block_lasts", lasts_seen, 1);
    chk("run_error", error_out, 0);

    $display("[TB] ZRL");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 15, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    chk("zrl_error", error_out, 0);

    $display("[TB] backpressure");
    bp_mode = 2;
    pat_i = 0;
    applyStimulus(1, 2, 0, 5, 20, 0);
    applyStimulus(0, 2, 3, 4, 2, 0);
    applyStimulus(0, 2, 0, 0, 0, 0);
    bp_mode = 0;

    $display("[TB] random blocks");
    for (int blk = 0; blk < 25; blk++) begin
      bp_mode = int'($urandom_range(0, 2));
      comp = int'($urandom_range(0, NC - 1));
      sz = int'($urandom_range(0, MS));
      applyStimulus(1, comp, 0, sz, randValue(sz), ($urandom_range(0, 7) == 0));
      while (idx_m != 0) begin
        k = int'($urandom_range(0, 11));
        r = int'($urandom_range(0, 9));
        if (k == 0) applyStimulus(0, comp, 0, 0, 0, 0);
        else if (k == 1) applyStimulus(0, comp, 15, 0, 0, 0);
        else if (k == 2) applyStimulus(0, comp, r, MS + 1 + int'($urandom_range(0, 19)), randValue(MS + 1), 0);
        else begin
          sz = int'($urandom_range(1, MS));
          applyStimulus(0, comp, r, sz, randValue(sz), 0);
        end
      end
      chk("rand_error", error_out, err_m);
    end
    bp_mode = 0;

    $display("[TB] error cases");
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 15, 0, 0, 0);
    applyStimulus(0, 0, 15, 0, 0, 0);
    applyStimulus(0, 0, 15, 0, 0, 0);
    applyStimulus(0, 0, 10, 1, 1, 0);
    chk("pre_overrun_error", error_out, 0);
    applyStimulus(0, 0, 15, 1, 1, 0);
    chk("overrun_error", error_out, 1);
    applyStimulus(0, 0, 0, 1, 1, 0);
    chk("no_dc_error", error_out, 1);

    $display("[TB] reset during fill");
    applyStimulus(0, 0, 0, 0, 0, 0, 5);
    rst_in = 1'b1;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_index", index_out, 0);
    chk("midrst_ready", ready_out, 0);
    chk("midrst_last", last_out, 0);
    chk("midrst_error", error_out, 0);
    exp_q.delete();
    idx_m = 0;
    err_m = 1'b0;
    for (int i = 0; i < NC; i++) pred_m[i] = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
    applyStimulus(1, 1, 0, 2, 3, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    chk("post_rst_error", error_out, 0);

    printSummary();
    $finish;
  end

endmodule
